// File: rtl/req_arbiter_8.sv
// Eight-input request arbiter: sticky pending capture, one-hot registered grant with valid/ready.
// Optional build macro REQ_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority (bit 0 highest).
module req_arbiter_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       grant_ready,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [7:0] pending
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] winner_c;
    logic             handshake_c;
    logic [N_REQ-1:0] clr_c;

`ifdef REQ_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;

    // First set bit of pend searching last+1, last+2, ... modulo 8.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                                 input logic [IDX_W-1:0] last);
        logic [N_REQ-1:0] result;
        logic             found;
        logic [IDX_W-1:0] idx;
        result = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + IDX_W'(k);
            if (!found && pend[idx]) begin
                result[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return result;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction
`else
    // Lowest set index wins.
    function automatic logic [N_REQ-1:0] fixed_pick(input logic [N_REQ-1:0] pend);
        logic [N_REQ-1:0] result;
        logic             found;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && pend[i]) begin
                result[i] = 1'b1;
                found     = 1'b1;
            end
        end
        return result;
    endfunction
`endif

    // Winner is chosen from the registered pending bits only, never from this cycle's req.
    always_comb begin
        winner_c = '0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
        winner_c = rr_pick(pending_q, last_q);
`else
        winner_c = fixed_pick(pending_q);
`endif
    end

    // Sticky capture; a new req on the accepted bit overrides its clear.
    always_comb begin
        handshake_c = 1'b0;
        clr_c       = '0;
        handshake_c = (state_q == ST_OFFER) && grant_ready;
        clr_c       = handshake_c ? grant_q : '0;
        pending_d   = (pending_q & ~clr_c) | req;
    end

    // Next-state and grant outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
`ifdef REQ_ARB_ROUND_ROBIN_EN
        last_d        = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                if (pending_q != '0) begin
                    grant_d       = winner_c;
                    grant_valid_d = 1'b1;
                    state_d       = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (grant_ready) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
`ifdef REQ_ARB_ROUND_ROBIN_EN
                    last_d        = onehot_to_idx(grant_q);
`endif
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            pending_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            pending_q     <= pending_d;
        end
    end

`ifdef REQ_ARB_ROUND_ROBIN_EN
    // Reset to 7 so bit 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= IDX_W'(N_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed self-checking bench for req_arbiter_8; round-robin scenario runs when REQ_ARB_ROUND_ROBIN_EN is defined.
module tb_req_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_ready;
    logic [7:0] grant;
    logic       grant_valid;
    logic [7:0] pending;

    int passed;
    int total;

    req_arbiter_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_ready (grant_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req         = 8'hFF;
        grant_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (pending !== 8'h00 || grant !== 8'h00 || grant_valid !== 1'b0)
                $display("FAIL reset_hold[%0d]: pending=%h grant=%h valid=%b, want 00 00 0", i, pending, grant, grant_valid);
            else passed++;
        end
        rst_n = 1'b1;
        req   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (pending !== 8'h00 || grant !== 8'h00 || grant_valid !== 1'b0)
                $display("FAIL reset_release[%0d]: pending=%h grant=%h valid=%b, want 00 00 0", i, pending, grant, grant_valid);
            else passed++;
        end
    endtask

    task automatic test_single();
        grant_ready = 1'b1;
        req         = 8'h10;
        step();
        total++;
        if (pending !== 8'h10 || grant_valid !== 1'b0)
            $display("FAIL single_capture: pending=%h valid=%b, want 10 0", pending, grant_valid);
        else passed++;
        req = 8'h00;
        step();
        total++;
        if (grant !== 8'h10 || grant_valid !== 1'b1)
            $display("FAIL single_grant: grant=%h valid=%b, want 10 1", grant, grant_valid);
        else passed++;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL single_done: grant=%h valid=%b pending=%h, want 00 0 00", grant, grant_valid, pending);
        else passed++;
    endtask

    task automatic test_backpressure();
        grant_ready = 1'b0;
        req         = 8'h04;
        step();
        req = 8'h00;
        step();
        total++;
        if (grant !== 8'h04 || grant_valid !== 1'b1)
            $display("FAIL bp_first: grant=%h valid=%b, want 04 1", grant, grant_valid);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            req = (i == 1) ? 8'h01 : 8'h00;
            step();
            total++;
            if (grant !== 8'h04 || grant_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: grant=%h valid=%b, want 04 1", i, grant, grant_valid);
            else passed++;
        end
        total++;
        if (pending !== 8'h05)
            $display("FAIL bp_pending: pending=%h, want 05", pending);
        else passed++;
        grant_ready = 1'b1;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h01)
            $display("FAIL bp_handshake: grant=%h valid=%b pending=%h, want 00 0 01", grant, grant_valid, pending);
        else passed++;
        step();
        total++;
        if (grant !== 8'h01 || grant_valid !== 1'b1)
            $display("FAIL bp_next: grant=%h valid=%b, want 01 1", grant, grant_valid);
        else passed++;
        step();
        total++;
        if (grant_valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL bp_drain: valid=%b pending=%h, want 0 00", grant_valid, pending);
        else passed++;
    endtask

    task automatic test_set_wins();
        grant_ready = 1'b0;
        req         = 8'h02;
        step();
        req = 8'h00;
        step();
        total++;
        if (grant !== 8'h02 || grant_valid !== 1'b1)
            $display("FAIL sw_grant: grant=%h valid=%b, want 02 1", grant, grant_valid);
        else passed++;
        grant_ready = 1'b1;
        req         = 8'h02;
        step();
        total++;
        if (grant_valid !== 1'b0 || pending !== 8'h02)
            $display("FAIL sw_collide: valid=%b pending=%h, want 0 02", grant_valid, pending);
        else passed++;
        req = 8'h00;
        step();
        total++;
        if (grant !== 8'h02 || grant_valid !== 1'b1)
            $display("FAIL sw_regrant: grant=%h valid=%b, want 02 1", grant, grant_valid);
        else passed++;
        step();
        total++;
        if (grant_valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL sw_drain: valid=%b pending=%h, want 0 00", grant_valid, pending);
        else passed++;
    endtask

    task automatic test_reset_mid_offer();
        grant_ready = 1'b0;
        req         = 8'h08;
        step();
        req = 8'h00;
        step();
        total++;
        if (grant !== 8'h08 || grant_valid !== 1'b1)
            $display("FAIL rmo_grant: grant=%h valid=%b, want 08 1", grant, grant_valid);
        else passed++;
        rst_n = 1'b0;
        req   = 8'hFF;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL rmo_drop: grant=%h valid=%b pending=%h, want 00 0 00", grant, grant_valid, pending);
        else passed++;
        rst_n = 1'b1;
        req   = 8'h00;
        step();
        total++;
        if (grant_valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL rmo_after: valid=%b pending=%h, want 0 00", grant_valid, pending);
        else passed++;
    endtask

`ifdef REQ_ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [7:0] exp_g;
        rst_n       = 1'b0;
        req         = 8'h00;
        grant_ready = 1'b1;
        step();
        rst_n = 1'b1;
        req   = 8'hFF;
        step();
        req = 8'h00;
        exp_g = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (grant !== exp_g || grant_valid !== 1'b1)
                $display("FAIL rr_sweep[%0d]: grant=%h valid=%b, want %h 1", i, grant, grant_valid, exp_g);
            else passed++;
            step();
            total++;
            if (grant_valid !== 1'b0)
                $display("FAIL rr_bubble[%0d]: valid=%b, want 0", i, grant_valid);
            else passed++;
            exp_g = exp_g << 1;
        end
        req = 8'h81;
        step();
        req = 8'h00;
        step();
        total++;
        if (grant !== 8'h01 || grant_valid !== 1'b1)
            $display("FAIL rr_81_first: grant=%h valid=%b, want 01 1", grant, grant_valid);
        else passed++;
        step();
        step();
        total++;
        if (grant !== 8'h80 || grant_valid !== 1'b1)
            $display("FAIL rr_81_second: grant=%h valid=%b, want 80 1", grant, grant_valid);
        else passed++;
        step();
    endtask
`else
    task automatic test_fixed_priority();
        grant_ready = 1'b1;
        req         = 8'h81;
        step();
        step();
        total++;
        if (grant !== 8'h01 || grant_valid !== 1'b1)
            $display("FAIL fp_first: grant=%h valid=%b, want 01 1", grant, grant_valid);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (k % 2 == 1) begin
                if (grant !== 8'h01 || grant_valid !== 1'b1)
                    $display("FAIL fp_hold[%0d]: grant=%h valid=%b, want 01 1", k, grant, grant_valid);
                else passed++;
            end else begin
                if (grant !== 8'h00 || grant_valid !== 1'b0)
                    $display("FAIL fp_bubble[%0d]: grant=%h valid=%b, want 00 0", k, grant, grant_valid);
                else passed++;
            end
        end
        req = 8'h00;
        step();
        total++;
        if (grant_valid !== 1'b0 || pending !== 8'h80)
            $display("FAIL fp_drop: valid=%b pending=%h, want 0 80", grant_valid, pending);
        else passed++;
        step();
        total++;
        if (grant !== 8'h80 || grant_valid !== 1'b1)
            $display("FAIL fp_low: grant=%h valid=%b, want 80 1", grant, grant_valid);
        else passed++;
        step();
        step();
        total++;
        if (grant_valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL fp_drain: valid=%b pending=%h, want 0 00", grant_valid, pending);
        else passed++;
    endtask
`endif

    initial begin
        passed      = 0;
        total       = 0;
        rst_n       = 1'b0;
        req         = 8'h00;
        grant_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_set_wins();
        test_reset_mid_offer();
`ifdef REQ_ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
